seq_detect_param: RTL and testbench



---
 rtl/seq_detect_param.sv | 113 +++++++++++
 tb/tb_seq_detect_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
`timescale 1ns/1ps
// seq_detect_param: parametrised serial sequence detector.
// Shifts in din (MSB-first) on each valid cycle and compares the last PAT_W
// bits against a runtime-loadable pattern. A match raises dout for one cycle
// and bumps a saturating match counter. ovl_en selects overlapping or
// non-overlapping matching.
// Optional build macro SEQ_DETECT_MASK_EN adds cfg_mask, which marks pattern
// positions as don't-care (mask bit = 1).
module seq_detect_param #(
   parameter int               PAT_W    = 4,
   parameter logic [PAT_W-1:0] PAT_INIT = 4'b1010,
   parameter int               CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_valid,
   input  logic             ovl_en,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
`ifdef SEQ_DETECT_MASK_EN
   input  logic [PAT_W-1:0] cfg_mask,
`endif
   input  logic             cnt_clr,
   output logic             dout,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int               FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [PAT_W-1:0]  r_pattern;
   logic [PAT_W-1:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic              r_dout;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_cnt_sat;
`ifdef SEQ_DETECT_MASK_EN
   logic [PAT_W-1:0]  r_mask;
`endif

   logic [PAT_W-1:0]  w_hist_next;
   logic [FILL_W-1:0] w_fill_next;
   logic              w_pat_hit;
   logic              w_match;
   logic [CNT_W-1:0]  w_cnt_next;

   // Next-state values for history/fill, match decision and counter update.
   // A bit presented together with cfg_load is dropped, so it can never match.
   always_comb begin
      w_hist_next = {r_hist[PAT_W-2:0], din};
      w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
`ifdef SEQ_DETECT_MASK_EN
      w_pat_hit   = ((w_hist_next ^ r_pattern) & ~r_mask) == '0;
`else
      w_pat_hit   = (w_hist_next == r_pattern);
`endif
      w_match     = din_valid && !cfg_load && (w_fill_next == FILL_FULL) && w_pat_hit;
      w_cnt_next  = r_cnt;
      if (cnt_clr) begin
         w_cnt_next = '0;
      end else if (w_match && (r_cnt != CNT_MAX)) begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end
   end

   // Pattern/mask configuration and the shift history with its fill count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pattern <= PAT_INIT;
`ifdef SEQ_DETECT_MASK_EN
         r_mask    <= '0;
`endif
         r_hist    <= '0;
         r_fill    <= '0;
      end else if (cfg_load) begin
         r_pattern <= cfg_pattern;
`ifdef SEQ_DETECT_MASK_EN
         r_mask    <= cfg_mask;
`endif
         r_hist    <= '0;
         r_fill    <= '0;
      end else if (din_valid) begin
         if (w_match && !ovl_en) begin
            r_hist <= '0;
            r_fill <= '0;
         end else begin
            r_hist <= w_hist_next;
            r_fill <= w_fill_next;
         end
      end
   end

   // Registered match pulse, saturating counter and its saturation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout    <= 1'b0;
         r_cnt     <= '0;
         r_cnt_sat <= 1'b0;
      end else begin
         r_dout    <= w_match;
         r_cnt     <= w_cnt_next;
         r_cnt_sat <= (w_cnt_next == CNT_MAX);
      end
   end

   assign dout      = r_dout;
   assign match_cnt = r_cnt;
   assign cnt_sat   = r_cnt_sat;

endmodule

// File: tb/tb_seq_detect_param.sv
`timescale 1ns/1ps
// Testbench for seq_detect_param (PAT_W = 4, CNT_W = 2 so saturation is reachable).
// Stimulus pushes the reference model's expected outputs into a queue; a monitor
// pops one entry per clock and compares it against the DUT.
module tb_seq_detect_param;

   localparam int PAT_W   = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_TOP = 3;

   logic             clk;
   logic             rst_n;
   logic             din;
   logic             din_valid;
   logic             ovl_en;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [PAT_W-1:0] cfg_mask;
   logic             cnt_clr;
   logic             dout;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;

   seq_detect_param #(
      .PAT_W    (PAT_W),
      .PAT_INIT (4'b1010),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .ovl_en      (ovl_en),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
`ifdef SEQ_DETECT_MASK_EN
      .cfg_mask    (cfg_mask),
`endif
      .cnt_clr     (cnt_clr),
      .dout        (dout),
      .match_cnt   (match_cnt),
      .cnt_sat     (cnt_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             dout;
      logic [CNT_W-1:0] cnt;
      logic             sat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: plain list of bits received since the last clear.
   bit               m_bits[$];
   logic [PAT_W-1:0] m_pat;
   logic [PAT_W-1:0] m_mask;
   int               m_cnt;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_pat  = 4'b1010;
      m_mask = '0;
      m_cnt  = 0;
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge clk);
      din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      rst_n = 1'b0;
      model_reset();
      e.dout = 1'b0; e.cnt = '0; e.sat = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step(input logic b, input logic v, input logic ovl, input logic ld,
                       input logic [PAT_W-1:0] pat, input logic [PAT_W-1:0] msk,
                       input logic clr);
      exp_t             e;
      bit               hit;
      logic [PAT_W-1:0] val;
      @(negedge clk);
      din = b; din_valid = v; ovl_en = ovl; cfg_load = ld;
      cfg_pattern = pat; cfg_mask = msk; cnt_clr = clr;
      hit = 1'b0;
      if (ld) begin
         m_pat = pat;
`ifdef SEQ_DETECT_MASK_EN
         m_mask = msk;
`else
         m_mask = '0;
`endif
         m_bits.delete();
      end else if (v) begin
         m_bits.push_back(b);
         if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
         if (m_bits.size() == PAT_W) begin
            val = '0;
            foreach (m_bits[i]) val = (val << 1) | PAT_W'(m_bits[i]);
            hit = (((val ^ m_pat) & ~m_mask) == '0);
            if (hit && !ovl) m_bits.delete();
         end
      end
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_TOP) m_cnt++;
      e.dout = hit;
      e.cnt  = CNT_W'(m_cnt);
      e.sat  = (m_cnt == CNT_TOP);
      exp_q.push_back(e);
   endtask

   task automatic feed(input logic b, input logic ovl);
      step(b, 1'b1, ovl, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, ovl_en, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic feed_stream(input logic ovl);
      logic [16:0] s;
      s = 17'b00101010001011100;
      for (int i = 16; i >= 0; i--) feed(s[i], ovl);
   endtask

   // Monitor: one expectation per clock, sampled 1 ns after the rising edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("dout", int'(dout), int'(mon_e.dout));
         chk("match_cnt", int'(match_cnt), int'(mon_e.cnt));
         chk("cnt_sat", int'(cnt_sat), int'(mon_e.sat));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; ovl_en = 1'b1;
      cfg_load = 1'b0; cfg_pattern = '0; cfg_mask = '0; cnt_clr = 1'b0;
      model_reset();
      do_reset();

      // Reference stream, overlapping then non-overlapping.
      feed_stream(1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b0000, 1'b1);
      feed_stream(1'b0);

      // Load 1011 with a valid bit in the load cycle; that bit is discarded.
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 4'b0000, 1'b1);
      feed_stream(1'b1);

      // Gapped valid: 1,0,1,0 with idle cycles in between.
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
         feed((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
      end
      idle(2);

      // Saturation: five overlapping matches, counter clear on the fifth.
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b0000, 1'b1);
      for (int i = 0; i < 12; i++)
         step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, (i == 11) ? 1'b1 : 1'b0);
      idle(2);

      // Reset mid-pattern: partial 1,0,1 is lost, then 0 must not match.
      feed(1'b1, 1'b1); feed(1'b0, 1'b1); feed(1'b1, 1'b1);
      do_reset();
      feed(1'b0, 1'b1);
      feed(1'b1, 1'b1); feed(1'b0, 1'b1); feed(1'b1, 1'b1); feed(1'b0, 1'b1);

      // Reset reverts a loaded pattern back to 1010.
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 4'b0000, 1'b0);
      do_reset();
      feed(1'b1, 1'b1); feed(1'b0, 1'b1); feed(1'b1, 1'b1); feed(1'b0, 1'b1);

`ifdef SEQ_DETECT_MASK_EN
      // Don't-care on the last position: 1,0,1,1 matches 1010/0001.
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b0001, 1'b1);
      feed(1'b1, 1'b1); feed(1'b0, 1'b1); feed(1'b1, 1'b1); feed(1'b1, 1'b1);
      idle(1);
`endif

      // Randomized traffic with occasional loads, clears and mode changes.
      for (int i = 0; i < 1500; i++) begin
         logic             b, v, o, l, c;
         logic [PAT_W-1:0] p, m;
         b = 1'($urandom_range(0, 1));
         v = ($urandom_range(0, 3) != 0);
         o = 1'($urandom_range(0, 1));
         l = ($urandom_range(0, 39) == 0);
         c = ($urandom_range(0, 29) == 0);
         p = PAT_W'($urandom_range(0, 15));
         m = ($urandom_range(0, 3) == 0) ? PAT_W'($urandom_range(0, 15)) : '0;
         step(b, v, o, l, p, m, c);
      end
      idle(2);

      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
